// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares a single-port data memory between the core (m0) and a
// loader/debug master (m1). Each access is held on the memory for MEM_LAT
// cycles, then the owner receives a one-cycle ack with registered read data.
// Arbitration is round-robin by default; defining DMEM_ARB_FIXED_PRIO_EN
// makes m0 win every contention instead.
module dmem_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  // core load/store master
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  // loader / debug master
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  // data memory
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  // status
  output logic              busy,
  output logic              owner
);

  // Counter wide enough for the legal MEM_LAT range 1..15.
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                prio_q, prio_d;
  logic                owner_q, owner_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   m0_rdata_q, m0_rdata_d;
  logic [DATA_W-1:0]   m1_rdata_q, m1_rdata_d;
  logic                m0_ack_q, m0_ack_d;
  logic                m1_ack_q, m1_ack_d;
  logic                mem_read_q, mem_read_d;
  logic                mem_write_q, mem_write_d;
  logic                busy_q, busy_d;
  logic                win_c;

  // Pick the master to grant when the arbiter is idle.
  always_comb begin
    win_c = 1'b0;
`ifdef DMEM_ARB_FIXED_PRIO_EN
    // m0 wins whenever it is requesting; m1 only gets the memory otherwise.
    win_c = ~m0_req;
`else
    // Contention resolved by the round-robin pointer, else the lone requester.
    if (m0_req && m1_req) begin
      win_c = prio_q;
    end else begin
      win_c = m1_req;
    end
`endif
  end

  // Next-state and registered-output logic of the grant FSM.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    prio_d     = prio_q;
    owner_d    = owner_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    m0_rdata_d = m0_rdata_q;
    m1_rdata_d = m1_rdata_q;
    m0_ack_d   = 1'b0;
    m1_ack_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (m0_req || m1_req) begin
          owner_d = win_c;
          we_d    = win_c ? m1_we    : m0_we;
          addr_d  = win_c ? m1_addr  : m0_addr;
          wdata_d = win_c ? m1_wdata : m0_wdata;
          cnt_d   = CNT_W'(MEM_LAT - 1);
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          // Last memory cycle: capture read data for the owner only.
          if (!we_q) begin
            if (owner_q) begin
              m1_rdata_d = mem_rdata;
            end else begin
              m0_rdata_d = mem_rdata;
            end
          end
          // Ack is raised together with entry into DONE.
          m0_ack_d = ~owner_q;
          m1_ack_d = owner_q;
          state_d  = DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        prio_d  = ~owner_q;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Memory strobes are high on exactly the cycles spent in ACCESS.
    mem_read_d  = (state_d == ACCESS) && !we_d;
    mem_write_d = (state_d == ACCESS) && we_d;
    busy_d      = (state_d != IDLE);
  end

  // State and output registers; async reset discards any access in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      prio_q      <= 1'b0;
      owner_q     <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
      m0_ack_q    <= 1'b0;
      m1_ack_q    <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      prio_q      <= prio_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      m0_rdata_q  <= m0_rdata_d;
      m1_rdata_q  <= m1_rdata_d;
      m0_ack_q    <= m0_ack_d;
      m1_ack_q    <= m1_ack_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      busy_q      <= busy_d;
    end
  end

  // Output mapping.
  assign m0_ack    = m0_ack_q;
  assign m1_ack    = m1_ack_q;
  assign m0_rdata  = m0_rdata_q;
  assign m1_rdata  = m1_rdata_q;
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = busy_q;
  assign owner     = owner_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: directed scenarios followed by random traffic,
// checked cycle by cycle against a transaction-timing reference model.
// Honours DMEM_ARB_FIXED_PRIO_EN when defined for the build.
module tb_dmem_arbiter;

  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int          LAT = 2;
`ifdef DMEM_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic          r_req   [2];
  logic          r_we    [2];
  logic [AW-1:0] r_addr  [2];
  logic [DW-1:0] r_wd    [2];
  logic          m0_ack, m1_ack, mem_read, mem_write, busy, owner;
  logic [DW-1:0] m0_rdata, m1_rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;

  // Behavioural memory attached to the DUT, word-indexed by addr[5:2].
  logic [DW-1:0] tb_mem [16];

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(r_req[0]), .m0_we(r_we[0]), .m0_addr(r_addr[0]), .m0_wdata(r_wd[0]),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(r_req[1]), .m1_we(r_we[1]), .m1_addr(r_addr[1]), .m1_wdata(r_wd[1]),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .owner(owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = tb_mem[mem_addr[5:2]];
  always @(posedge clk) if (mem_write) tb_mem[mem_addr[5:2]] <= mem_wdata;

  int checks = 0;
  int failures = 0;

  // Reference model: one transaction at a time, timed from its grant edge.
  int            k;
  bit            in_flight;
  int            g_edge;
  bit            g_own, g_we;
  logic [AW-1:0] g_addr;
  logic [DW-1:0] g_wd;
  int            idle_from;
  bit            prio;
  bit            exp_owner;
  logic [DW-1:0] rd_exp  [2];
  logic [DW-1:0] ref_mem [16];
  bit            ack_exp [2];
  bit            granted [2];
  int            grants_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  task automatic model_reset();
    in_flight = 1'b0; prio = 1'b0; exp_owner = 1'b0; idle_from = 0;
    rd_exp[0] = '0; rd_exp[1] = '0;
    granted[0] = 1'b0; granted[1] = 1'b0;
    ack_exp[0] = 1'b0; ack_exp[1] = 1'b0;
  endtask

  task automatic check_outputs();
    bit acc;
    acc = rst_n && in_flight && (k >= g_edge) && (k < g_edge + LAT);
    check("mem_read", 32'(mem_read), 32'(acc && !g_we));
    check("mem_write", 32'(mem_write), 32'(acc && g_we));
    if (acc) begin
      check("mem_addr", mem_addr, g_addr);
      check("mem_wdata", mem_wdata, g_wd);
    end
    check("m0_ack", 32'(m0_ack), 32'(ack_exp[0]));
    check("m1_ack", 32'(m1_ack), 32'(ack_exp[1]));
    check("two_acks", 32'(m0_ack & m1_ack), 32'd0);
    check("busy", 32'(busy), 32'(in_flight));
    check("owner", 32'(owner), 32'(exp_owner));
    check("m0_rdata", m0_rdata, rd_exp[0]);
    check("m1_rdata", m1_rdata, rd_exp[1]);
  endtask

  // Advance one clock: update the model at the edge, check at the falling edge.
  task automatic step();
    bit win;
    @(posedge clk);
    k++;
    ack_exp[0] = 1'b0; ack_exp[1] = 1'b0;
    if (!rst_n) begin
      model_reset();
    end else begin
      if (in_flight && k == g_edge + LAT) begin
        if (g_we) ref_mem[g_addr[5:2]] = g_wd;
        else      rd_exp[g_own] = ref_mem[g_addr[5:2]];
        ack_exp[g_own] = 1'b1;
        granted[g_own] = 1'b0;
      end
      if (in_flight && k == g_edge + LAT + 1) begin
        in_flight = 1'b0;
        prio = ~g_own;
      end
      if (!in_flight && k >= idle_from && (r_req[0] || r_req[1])) begin
        if (r_req[0] && r_req[1]) win = FIXED ? 1'b0 : prio;
        else                      win = r_req[1];
        in_flight = 1'b1; g_edge = k; g_own = win;
        g_we = r_we[win]; g_addr = r_addr[win]; g_wd = r_wd[win];
        idle_from = k + LAT + 2;
        exp_owner = win;
        granted[win] = 1'b1;
        grants_q.push_back(int'(win));
      end
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic drive_new(input int m);
    r_req[m]  = 1'b1;
    r_we[m]   = 1'($urandom_range(0, 1));
    r_addr[m] = $urandom;
    r_wd[m]   = $urandom;
  endtask

  // One isolated access by master m; reports ack step index and active cycles.
  task automatic single(input int m, input bit we, input logic [31:0] a,
                        input logic [31:0] d, output int ack_at, output int act_cnt);
    r_req[m] = 1'b1; r_we[m] = we; r_addr[m] = a; r_wd[m] = d;
    ack_at = 0; act_cnt = 0;
    for (int i = 1; i <= LAT + 4; i++) begin
      step();
      if (mem_read || mem_write) begin
        act_cnt++;
        check("single_addr", mem_addr, a);
      end
      if ((m == 0) ? m0_ack : m1_ack) begin
        ack_at = i;
        r_req[m] = 1'b0;
      end
      check("single_other_ack", 32'((m == 0) ? m1_ack : m0_ack), 32'd0);
    end
    r_req[m] = 1'b0;
  endtask

  initial begin
    int ack_at, act_cnt, n_grants, expw;
    bit stop;
    for (int m = 0; m < 2; m++) begin
      r_req[m] = 1'b0; r_we[m] = 1'b0; r_addr[m] = '0; r_wd[m] = '0;
    end
    for (int i = 0; i < 16; i++) begin
      tb_mem[i] = $urandom;
      ref_mem[i] = tb_mem[i];
    end
    k = 0; g_edge = 0; g_own = 0; g_we = 0; g_addr = '0; g_wd = '0;
    model_reset();
    rst_n = 1'b0;

    // Reset values.
    step();
    step();
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    rst_n = 1'b1;
    step();

    // m0 read of 0x10 returning 0xDEADBEEF.
    tb_mem[4] = 32'hDEADBEEF; ref_mem[4] = 32'hDEADBEEF;
    single(0, 1'b0, 32'h10, 32'h0, ack_at, act_cnt);
    check("rd_active_cycles", 32'(act_cnt), 32'(LAT));
    check("rd_ack_latency", 32'(ack_at), 32'(LAT + 1));
    check("rd_data", m0_rdata, 32'hDEADBEEF);

    // m1 write of 0x12345678 to 0x20; m1_rdata stays at reset value.
    single(1, 1'b1, 32'h20, 32'h12345678, ack_at, act_cnt);
    check("wr_active_cycles", 32'(act_cnt), 32'(LAT));
    check("wr_ack_latency", 32'(ack_at), 32'(LAT + 1));
    check("wr_m1_rdata", m1_rdata, 32'h0);
    check("wr_mem_content", tb_mem[8], 32'h12345678);

    // Both masters request continuously for four grants, then m0 backs off.
    grants_q.delete();
    drive_new(0); drive_new(1);
    stop = 1'b0;
    for (int i = 0; i < 80 && !stop; i++) begin
      step();
      for (int m = 0; m < 2; m++) begin
        if (ack_exp[m]) begin
          n_grants = grants_q.size();
          if (n_grants < 4) drive_new(m);
          else if (n_grants == 4) begin
            if (m == 0) r_req[0] = 1'b0;
            else begin r_req[1] = 1'b0; drive_new(1); r_req[0] = 1'b0; end
          end else begin
            r_req[m] = 1'b0;
            stop = 1'b1;
          end
        end
      end
    end
    check("contend_done", 32'(stop), 32'd1);
    for (int i = 0; i < 4; i++) begin
      expw = FIXED ? 0 : (i % 2);
      check("grant_order", 32'((i < grants_q.size()) ? grants_q[i] : -1), 32'(expw));
    end
    check("grant_after_m0_drop", 32'((grants_q.size() > 4) ? grants_q[4] : -1), 32'd1);
    r_req[0] = 1'b0; r_req[1] = 1'b0;
    repeat (3) step();

    // m0 read so the pointer moves to m1, then reset during an m0 write.
    single(0, 1'b0, 32'h14, 32'h0, ack_at, act_cnt);
    r_req[0] = 1'b1; r_we[0] = 1'b1; r_addr[0] = 32'h30; r_wd[0] = ref_mem[12];
    step();
    step();
    check("pre_rst_write", 32'(mem_write), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_write_drop", 32'(mem_write), 32'd0);
    check("rst_read_drop", 32'(mem_read), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    model_reset();
    r_req[0] = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (LAT + 2) step();
    // Pointer back at m0: a contended request must go to m0 first.
    grants_q.delete();
    drive_new(0); drive_new(1);
    step();
    check("post_rst_first_grant", 32'((grants_q.size() > 0) ? grants_q[0] : -1), 32'd0);
    for (int i = 0; i < 3 * (LAT + 2); i++) begin
      for (int m = 0; m < 2; m++) if (ack_exp[m]) r_req[m] = 1'b0;
      step();
    end
    r_req[0] = 1'b0; r_req[1] = 1'b0;
    repeat (LAT + 2) step();

    // m0 read then m1 read: each master's rdata is independent.
    tb_mem[0] = 32'h0BADF00D; ref_mem[0] = 32'h0BADF00D;
    tb_mem[1] = 32'hA5A5A5A5; ref_mem[1] = 32'hA5A5A5A5;
    single(0, 1'b0, 32'h40, 32'h0, ack_at, act_cnt);
    single(1, 1'b0, 32'h44, 32'h0, ack_at, act_cnt);
    check("m1_read_latency", 32'(ack_at), 32'(LAT + 1));
    check("m0_rdata_held", m0_rdata, 32'h0BADF00D);
    check("m1_rdata_new", m1_rdata, 32'hA5A5A5A5);

    // Random traffic with withdrawals.
    for (int i = 0; i < 600; i++) begin
      for (int m = 0; m < 2; m++) begin
        if (ack_exp[m]) begin
          r_req[m] = 1'b0;
          if ($urandom_range(0, 1) == 1) drive_new(m);
        end else if (r_req[m] && !granted[m] && $urandom_range(0, 15) == 0) begin
          r_req[m] = 1'b0;
        end else if (!r_req[m] && $urandom_range(0, 3) == 0) begin
          drive_new(m);
        end
      end
      step();
    end
    for (int m = 0; m < 2; m++) if (!granted[m]) r_req[m] = 1'b0;
    for (int i = 0; i < 3 * (LAT + 2); i++) begin
      step();
      for (int m = 0; m < 2; m++) if (ack_exp[m]) r_req[m] = 1'b0;
    end
    check("drain_idle", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
